sfx_sequencer: RTL and testbench

- Game-side driver for the tone generator's `play_sound` input; sits between game control logic and the speaker tone block.
- Turns single-cycle game event pulses (block placed, perfect stack, game lost) into timed note sequences.
- Outputs a gate (`play_sound`) plus a note index that selects the tone divider.
- Exposes `busy` and a `done` pulse so control logic can wait on effect completion.

---
 rtl/sfx_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_sfx_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sfx_sequencer.sv
// ---------------------------------------------------------------------------
// sfx_sequencer
//   Converts single-cycle game event pulses into timed note sequences that
//   drive the speaker tone generator. Each effect is a short list of steps
//   held in an internal ROM; every step has a note, a duration in sequencer
//   ticks, an on/off flag, and a last-step marker.
//
// Parameters
//   TICK_DIV : clock cycles per sequencer tick (legal 2 .. 2^24-1)
//   NOTE_W   : width of the note index output (at least 3)
//
// Ports
//   clock        : system clock, all state on the rising edge
//   reset        : asynchronous, active-high reset
//   evt_place    : one-cycle pulse, block placed
//   evt_perfect  : one-cycle pulse, perfectly aligned placement
//   evt_lose     : one-cycle pulse, game over
//   play_sound   : tone gate to the speaker generator (1 = sound on)
//   note         : tone select, valid while play_sound = 1, otherwise 0
//   busy         : 1 while an effect is in progress
//   done         : one-cycle pulse when an effect finishes or is preempted
// ---------------------------------------------------------------------------
module sfx_sequencer #(
  parameter int TICK_DIV = 1000000,
  parameter int NOTE_W   = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              evt_place,
  input  logic              evt_perfect,
  input  logic              evt_lose,
  output logic              play_sound,
  output logic [NOTE_W-1:0] note,
  output logic              busy,
  output logic              done
);

  localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    FX_PLACE   = 2'd0,
    FX_PERFECT = 2'd1,
    FX_LOSE    = 2'd2
  } effect_t;

  typedef struct packed {
    logic [2:0] note;
    logic [4:0] dur;
    logic       on;
    logic       last;
  } step_t;

  // Step ROM. Unused slots return a short silent last step so a corrupted
  // step pointer always drains back to idle.
  function automatic step_t step_rom(input effect_t fx, input logic [1:0] idx);
    step_t s;
    s = '{note: 3'd0, dur: 5'd1, on: 1'b0, last: 1'b1};
    case (fx)
      FX_PLACE: begin
        case (idx)
          2'd0:    s = '{note: 3'd4, dur: 5'd5,  on: 1'b1, last: 1'b1};
          default: s = '{note: 3'd0, dur: 5'd1,  on: 1'b0, last: 1'b1};
        endcase
      end
      FX_PERFECT: begin
        case (idx)
          2'd0:    s = '{note: 3'd4, dur: 5'd4,  on: 1'b1, last: 1'b0};
          2'd1:    s = '{note: 3'd0, dur: 5'd2,  on: 1'b0, last: 1'b0};
          2'd2:    s = '{note: 3'd6, dur: 5'd8,  on: 1'b1, last: 1'b1};
          default: s = '{note: 3'd0, dur: 5'd1,  on: 1'b0, last: 1'b1};
        endcase
      end
      FX_LOSE: begin
        case (idx)
          2'd0:    s = '{note: 3'd5, dur: 5'd10, on: 1'b1, last: 1'b0};
          2'd1:    s = '{note: 3'd3, dur: 5'd10, on: 1'b1, last: 1'b0};
          2'd2:    s = '{note: 3'd1, dur: 5'd20, on: 1'b1, last: 1'b1};
          default: s = '{note: 3'd0, dur: 5'd1,  on: 1'b0, last: 1'b1};
        endcase
      end
      default: s = '{note: 3'd0, dur: 5'd1, on: 1'b0, last: 1'b1};
    endcase
    return s;
  endfunction

  state_t              state_r, state_s;
  effect_t             fx_r, fx_s;
  logic [1:0]          step_r, step_s;
  logic [PRESC_W-1:0]  presc_r, presc_s;
  logic [4:0]          tick_r, tick_s;
  logic [4:0]          dur_r, dur_s;
  logic                last_r, last_s;
  logic                play_r, play_s;
  logic [NOTE_W-1:0]   note_r, note_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;

  logic                evt_any_s;
  effect_t             evt_fx_s;
  logic                load_s, adv_s, idle_s;
  effect_t             sel_fx_s;
  logic [1:0]          sel_idx_s;
  step_t               nxt_s;

  // Event priority: lose beats perfect beats place; losers are dropped.
  always_comb begin
    evt_any_s = evt_place | evt_perfect | evt_lose;
    if (evt_lose) begin
      evt_fx_s = FX_LOSE;
    end else if (evt_perfect) begin
      evt_fx_s = FX_PERFECT;
    end else begin
      evt_fx_s = FX_PLACE;
    end
  end

  // Next-state and registered-output logic for the sequencer FSM.
  always_comb begin
    state_s = state_r;
    fx_s    = fx_r;
    step_s  = step_r;
    presc_s = presc_r;
    tick_s  = tick_r;
    dur_s   = dur_r;
    last_s  = last_r;
    play_s  = play_r;
    note_s  = note_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    load_s  = 1'b0;
    adv_s   = 1'b0;
    idle_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (evt_any_s) begin
          load_s = 1'b1;
        end else begin
          idle_s = 1'b1;
        end
      end
      ST_PLAY: begin
        if (evt_lose && (fx_r != FX_LOSE)) begin
          // Preemption: report the aborted effect and restart on LOSE.
          load_s = 1'b1;
          done_s = 1'b1;
        end else if (presc_r == PRESC_MAX) begin
          if ((tick_r + 5'd1) == dur_r) begin
            if (last_r) begin
              done_s = 1'b1;
              // A new event on the finishing edge loads immediately, so
              // busy never drops between back-to-back effects.
              if (evt_any_s) begin
                load_s = 1'b1;
              end else begin
                idle_s = 1'b1;
              end
            end else begin
              adv_s = 1'b1;
            end
          end else begin
            presc_s = '0;
            tick_s  = tick_r + 5'd1;
          end
        end else begin
          presc_s = presc_r + PRESC_W'(1);
        end
      end
      default: idle_s = 1'b1;
    endcase

    // One ROM lookup serves both a fresh load and a step advance.
    sel_fx_s  = load_s ? evt_fx_s : fx_r;
    sel_idx_s = load_s ? 2'd0 : (step_r + 2'd1);
    nxt_s     = step_rom(sel_fx_s, sel_idx_s);

    if (load_s || adv_s) begin
      state_s = ST_PLAY;
      fx_s    = sel_fx_s;
      step_s  = sel_idx_s;
      presc_s = '0;
      tick_s  = 5'd0;
      dur_s   = nxt_s.dur;
      last_s  = nxt_s.last;
      busy_s  = 1'b1;
      play_s  = nxt_s.on;
      note_s  = nxt_s.on ? NOTE_W'(nxt_s.note) : '0;
    end else if (idle_s) begin
      state_s = ST_IDLE;
      fx_s    = FX_PLACE;
      step_s  = 2'd0;
      presc_s = '0;
      tick_s  = 5'd0;
      dur_s   = 5'd0;
      last_s  = 1'b0;
      busy_s  = 1'b0;
      play_s  = 1'b0;
      note_s  = '0;
    end else begin
      // Mid-step: only the prescaler / tick counters moved above.
      state_s = state_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      fx_r    <= FX_PLACE;
      step_r  <= 2'd0;
      presc_r <= '0;
      tick_r  <= 5'd0;
      dur_r   <= 5'd0;
      last_r  <= 1'b0;
      play_r  <= 1'b0;
      note_r  <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      fx_r    <= fx_s;
      step_r  <= step_s;
      presc_r <= presc_s;
      tick_r  <= tick_s;
      dur_r   <= dur_s;
      last_r  <= last_s;
      play_r  <= play_s;
      note_r  <= note_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign play_sound = play_r;
  assign note       = note_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_sfx_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sfx_sequencer
//   Self-checking bench for sfx_sequencer with TICK_DIV = 4. A timeline
//   model (effect kind + cycles elapsed since load) predicts the outputs
//   every cycle; directed steps cover the documented scenarios, followed by
//   a stretch of random events.
// ---------------------------------------------------------------------------
module tb_sfx_sequencer;

  localparam int TD = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       evt_place, evt_perfect, evt_lose;
  logic       play_sound;
  logic [2:0] note;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  sfx_sequencer #(.TICK_DIV(TD), .NOTE_W(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .evt_place   (evt_place),
    .evt_perfect (evt_perfect),
    .evt_lose    (evt_lose),
    .play_sound  (play_sound),
    .note        (note),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  // Effect tables: 0 = place, 1 = perfect, 2 = lose. Durations in ticks.
  int nsteps [3]    = '{1, 3, 3};
  int durs   [3][3] = '{'{5, 0, 0}, '{4, 2, 8}, '{10, 10, 20}};
  int notes  [3][3] = '{'{4, 0, 0}, '{4, 0, 6}, '{5, 3, 1}};
  int ons    [3][3] = '{'{1, 0, 0}, '{1, 0, 1}, '{1, 1, 1}};

  int   m_active = 0;
  int   m_eff    = 0;
  int   m_el     = 0;
  logic m_done   = 1'b0;

  function automatic int total_len(input int e);
    int t = 0;
    for (int s = 0; s < nsteps[e]; s++) t += durs[e][s] * TD;
    return t;
  endfunction

  function automatic int pick(input logic p, input logic f, input logic l);
    if (l) return 2;
    if (f) return 1;
    return 0;
  endfunction

  task automatic model_edge(input logic p, input logic f, input logic l);
    logic any;
    any    = p | f | l;
    m_done = 1'b0;
    if (m_active != 0) begin
      m_el++;
      if (l && (m_eff != 2)) begin
        m_done = 1'b1;
        m_eff  = 2;
        m_el   = 0;
      end else if (m_el == total_len(m_eff)) begin
        m_done   = 1'b1;
        m_active = 0;
        if (any) begin
          m_active = 1;
          m_eff    = pick(p, f, l);
          m_el     = 0;
        end
      end
    end else if (any) begin
      m_active = 1;
      m_eff    = pick(p, f, l);
      m_el     = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag);
    logic       ep, eb;
    logic [2:0] en;
    int         acc;
    ep = 1'b0; en = 3'd0; eb = 1'b0; acc = 0;
    if (m_active != 0) begin
      eb = 1'b1;
      for (int s = 0; s < nsteps[m_eff]; s++) begin
        if ((m_el >= acc) && (m_el < acc + durs[m_eff][s] * TD)) begin
          ep = (ons[m_eff][s] != 0);
          en = ep ? 3'(notes[m_eff][s]) : 3'd0;
        end
        acc += durs[m_eff][s] * TD;
      end
    end
    chk({tag, ".outs"}, {28'd0, play_sound, note, busy, done}, {28'd0, ep, en, eb, m_done});
  endtask

  // One clock cycle: drive events, let the edge happen, check at negedge.
  task automatic cyc(input string tag, input logic p, input logic f, input logic l);
    evt_place   = p;
    evt_perfect = f;
    evt_lose    = l;
    @(posedge clock);
    model_edge(p, f, l);
    @(negedge clock);
    evt_place   = 1'b0;
    evt_perfect = 1'b0;
    evt_lose    = 1'b0;
    check_out(tag);
  endtask

  task automatic run_until_idle(input string tag, input int n0, input int exp_len);
    int n;
    int guard;
    n = n0;
    guard = 0;
    while (busy === 1'b1 && guard < 400) begin
      cyc(tag, 1'b0, 1'b0, 1'b0);
      if (busy === 1'b1) n++;
      guard++;
    end
    chk({tag, ".timeout"}, {31'd0, (guard >= 400)}, 32'd0);
    if (exp_len > 0) chk({tag, ".busy_len"}, n, exp_len);
  endtask

  initial begin
    int r;
    reset       = 1'b1;
    evt_place   = 1'b0;
    evt_perfect = 1'b0;
    evt_lose    = 1'b0;
    repeat (3) @(negedge clock);
    check_out("reset");
    reset = 1'b0;
    repeat (6) cyc("idle", 1'b0, 1'b0, 1'b0);

    // Single PLACE effect: 20 busy cycles then one done.
    cyc("place", 1'b1, 1'b0, 1'b0);
    run_until_idle("place", 1, 20);
    repeat (3) cyc("post_place", 1'b0, 1'b0, 1'b0);

    // PERFECT effect: 16 on + 8 off + 32 on.
    cyc("perfect", 1'b0, 1'b1, 1'b0);
    run_until_idle("perfect", 1, 56);
    repeat (3) cyc("post_perfect", 1'b0, 1'b0, 1'b0);

    // All three events together: LOSE wins.
    cyc("all3", 1'b1, 1'b1, 1'b1);
    run_until_idle("all3", 1, 160);
    repeat (3) cyc("post_all3", 1'b0, 1'b0, 1'b0);

    // PLACE preempted by LOSE 8 cycles later; second LOSE ignored.
    cyc("pre_place", 1'b1, 1'b0, 1'b0);
    repeat (7) cyc("pre_wait", 1'b0, 1'b0, 1'b0);
    cyc("preempt", 1'b0, 1'b0, 1'b1);
    chk("preempt.done", {31'd0, done}, 32'd1);
    chk("preempt.note", {29'd0, note}, 32'd5);
    repeat (50) cyc("lose_mid", 1'b0, 1'b0, 1'b0);
    cyc("lose_again", 1'b0, 1'b0, 1'b1);
    run_until_idle("preempt", 52, 160);
    repeat (3) cyc("post_preempt", 1'b0, 1'b0, 1'b0);

    // PERFECT during PLACE is ignored.
    cyc("place2", 1'b1, 1'b0, 1'b0);
    repeat (5) cyc("place2_wait", 1'b0, 1'b0, 1'b0);
    cyc("perf_ignored", 1'b0, 1'b1, 1'b0);
    run_until_idle("place2", 7, 20);
    repeat (3) cyc("post_place2", 1'b0, 1'b0, 1'b0);

    // New event on the very edge PLACE finishes: done plus immediate load.
    cyc("b2b_place", 1'b1, 1'b0, 1'b0);
    repeat (19) cyc("b2b_wait", 1'b0, 1'b0, 1'b0);
    cyc("b2b_perfect", 1'b0, 1'b1, 1'b0);
    chk("b2b.done", {31'd0, done}, 32'd1);
    chk("b2b.busy", {31'd0, busy}, 32'd1);
    run_until_idle("b2b", 1, 56);
    repeat (3) cyc("post_b2b", 1'b0, 1'b0, 1'b0);

    // Reset 6 cycles into LOSE: outputs clear asynchronously, no done.
    cyc("rst_lose", 1'b0, 1'b0, 1'b1);
    repeat (5) cyc("rst_wait", 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    m_active = 0;
    m_done   = 1'b0;
    #1 check_out("async_reset");
    evt_place   = 1'b1;
    evt_perfect = 1'b1;
    evt_lose    = 1'b1;
    repeat (2) begin
      @(negedge clock);
      check_out("reset_held");
    end
    evt_place   = 1'b0;
    evt_perfect = 1'b0;
    evt_lose    = 1'b0;
    reset       = 1'b0;
    cyc("after_reset", 1'b0, 1'b0, 1'b0);
    cyc("place3", 1'b1, 1'b0, 1'b0);
    run_until_idle("place3", 1, 20);

    // Random events against the timeline model.
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      cyc("random", (r < 4) || (r == 8), ((r >= 4) && (r < 7)) || (r == 8), (r == 7) || (r == 8));
    end
    run_until_idle("drain", 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
